// File: rtl/gps_corr_dump_fifo_pkg.sv
// ---------------------------------------------------------------------------
// gps_corr_dump_fifo_pkg
// Shared definitions for the correlator dump capture path: default widths and
// the bit layout of one captured entry. The register map reads the same
// offsets, so entry layout changes must happen here only.
//
// Entry layout (LSB first): ql, il, qe, ie, qp, ip, tstamp, acq, seq.
// ---------------------------------------------------------------------------
package gps_corr_dump_fifo_pkg;

    localparam int DW_DEF  = 20;   // accumulator word width
    localparam int TSW_DEF = 32;   // timestamp width
    localparam int SEQ_W   = 8;    // sequence number width
    localparam int OVF_W   = 8;    // overflow counter width

    // Accumulator slots within an entry, in ascending bit order.
    typedef enum logic [2:0] {
        F_QL = 3'd0,
        F_IL = 3'd1,
        F_QE = 3'd2,
        F_IE = 3'd3,
        F_QP = 3'd4,
        F_IP = 3'd5
    } acc_field_e;

    function automatic int off_acc(acc_field_e f, int dw);
        return int'(f) * dw;
    endfunction

    function automatic int off_ts(int dw);
        return 6 * dw;
    endfunction

    function automatic int off_acq(int dw, int tsw);
        return 6 * dw + tsw;
    endfunction

    function automatic int off_seq(int dw, int tsw);
        return 6 * dw + tsw + 1;
    endfunction

    function automatic int entry_w(int dw, int tsw);
        return 6 * dw + tsw + 1 + SEQ_W;
    endfunction

    // Offsets at default widths (161-bit entry).
    localparam int OFF_QL  = off_acc(F_QL, DW_DEF);
    localparam int OFF_IL  = off_acc(F_IL, DW_DEF);
    localparam int OFF_QE  = off_acc(F_QE, DW_DEF);
    localparam int OFF_IE  = off_acc(F_IE, DW_DEF);
    localparam int OFF_QP  = off_acc(F_QP, DW_DEF);
    localparam int OFF_IP  = off_acc(F_IP, DW_DEF);
    localparam int OFF_TS  = off_ts(DW_DEF);
    localparam int OFF_ACQ = off_acq(DW_DEF, TSW_DEF);
    localparam int OFF_SEQ = off_seq(DW_DEF, TSW_DEF);
    localparam int ENTRY_W = entry_w(DW_DEF, TSW_DEF);

endpackage

// File: rtl/gps_corr_dump_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// gps_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented
// combinationally from storage; it reads as zero while the FIFO is empty.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   push_i, wdata_i write request and data (accepted if not full or popping)
//   pop_i           consume head entry (ignored when empty)
//   flush_i         empty the FIFO; overrides push and pop
//   rdata_o         head entry
//   level_o         stored entry count
//   full_o, empty_o status
// ---------------------------------------------------------------------------
module gps_sync_fifo #(
    parameter int WIDTH = 161,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    // Full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; empty state masks its contents.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/gps_corr_dump_fifo.sv
// ---------------------------------------------------------------------------
// gps_corr_dump_fifo
// Captures one correlator dump (six accumulators, timestamp, acq flag) per
// rising edge of dump_i into a FWFT FIFO, tagging each capture with an 8-bit
// sequence number and counting captures dropped because the FIFO was full.
//
// Ports:
//   mclk, mrst               clock, asynchronous active-high reset
//   dump_i                   dump strobe level; rising edge captures
//   acq_i, tstamp_i          acquisition flag and timestamp to capture
//   ip_i..ql_i               prompt/early/late I/Q accumulators to capture
//   pop_i, flush_i           consume head / discard all entries
//   clr_ovf_i                clear overflow flag and counter
//   rd_valid_o, rd_*_o       head entry (FWFT)
//   level_o, full_o          occupancy
//   ovf_o, ovf_cnt_o         sticky overflow flag, saturating drop count
// ---------------------------------------------------------------------------
module gps_corr_dump_fifo
    import gps_corr_dump_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 20,
    parameter int TSW   = 32
) (
    input  logic                     mclk,
    input  logic                     mrst,
    input  logic                     dump_i,
    input  logic                     acq_i,
    input  logic [DW-1:0]            ip_i,
    input  logic [DW-1:0]            qp_i,
    input  logic [DW-1:0]            ie_i,
    input  logic [DW-1:0]            qe_i,
    input  logic [DW-1:0]            il_i,
    input  logic [DW-1:0]            ql_i,
    input  logic [TSW-1:0]           tstamp_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     clr_ovf_i,
    output logic                     rd_valid_o,
    output logic [DW-1:0]            rd_ip_o,
    output logic [DW-1:0]            rd_qp_o,
    output logic [DW-1:0]            rd_ie_o,
    output logic [DW-1:0]            rd_qe_o,
    output logic [DW-1:0]            rd_il_o,
    output logic [DW-1:0]            rd_ql_o,
    output logic [TSW-1:0]           rd_tstamp_o,
    output logic                     rd_acq_o,
    output logic [SEQ_W-1:0]         rd_seq_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     ovf_o,
    output logic [OVF_W-1:0]         ovf_cnt_o
);

    localparam int EW   = entry_w(DW, TSW);
    localparam int O_QL = off_acc(F_QL, DW);
    localparam int O_IL = off_acc(F_IL, DW);
    localparam int O_QE = off_acc(F_QE, DW);
    localparam int O_IE = off_acc(F_IE, DW);
    localparam int O_QP = off_acc(F_QP, DW);
    localparam int O_IP = off_acc(F_IP, DW);
    localparam int O_TS = off_ts(DW);
    localparam int O_AQ = off_acq(DW, TSW);
    localparam int O_SQ = off_seq(DW, TSW);

    logic             dump_q;
    logic             armed_q;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             ovf_q, ovf_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             capture, pop_eff, reject, push;
    logic             fifo_full, fifo_empty;
    logic [EW-1:0]    wr_entry, rd_entry;

    // armed_q keeps a strobe that is already high at reset release from
    // counting as an edge; the strobe must be seen low first.
    assign capture = dump_i & ~dump_q & armed_q;
    assign pop_eff = pop_i & ~fifo_empty;
    assign reject  = capture & fifo_full & ~pop_eff;
    assign push    = capture & ~reject;

    assign wr_entry = {seq_q, acq_i, tstamp_i, ip_i, qp_i, ie_i, qe_i, il_i, ql_i};

    always_comb begin
        seq_d     = seq_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (capture) seq_d = seq_q + SEQ_W'(1);
        // Clear first so a same-cycle drop leaves a count of one.
        if (clr_ovf_i) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end
        if (reject) begin
            ovf_d = 1'b1;
            if (ovf_cnt_d != {OVF_W{1'b1}}) ovf_cnt_d = ovf_cnt_d + OVF_W'(1);
        end
    end

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            dump_q    <= 1'b0;
            armed_q   <= 1'b0;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            dump_q    <= dump_i;
            if (!dump_i) armed_q <= 1'b1;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    gps_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (mclk),
        .rst_i   (mrst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop_i),
        .flush_i (flush_i),
        .rdata_o (rd_entry),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rd_valid_o  = ~fifo_empty;
    assign full_o      = fifo_full;
    assign ovf_o       = ovf_q;
    assign ovf_cnt_o   = ovf_cnt_q;
    assign rd_ql_o     = rd_entry[O_QL +: DW];
    assign rd_il_o     = rd_entry[O_IL +: DW];
    assign rd_qe_o     = rd_entry[O_QE +: DW];
    assign rd_ie_o     = rd_entry[O_IE +: DW];
    assign rd_qp_o     = rd_entry[O_QP +: DW];
    assign rd_ip_o     = rd_entry[O_IP +: DW];
    assign rd_tstamp_o = rd_entry[O_TS +: TSW];
    assign rd_acq_o    = rd_entry[O_AQ];
    assign rd_seq_o    = rd_entry[O_SQ +: SEQ_W];

endmodule

// File: tb/tb_gps_corr_dump_fifo.sv
module tb_gps_corr_dump_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 20;
    localparam int TSW   = 32;
    localparam int EW    = 6 * DW + TSW + 1 + 8;

    logic            mclk = 1'b0;
    logic            mrst;
    logic            dump_i, acq_i, pop_i, flush_i, clr_ovf_i;
    logic [DW-1:0]   ip_i, qp_i, ie_i, qe_i, il_i, ql_i;
    logic [TSW-1:0]  tstamp_i;
    logic            rd_valid_o, rd_acq_o, full_o, ovf_o;
    logic [DW-1:0]   rd_ip_o, rd_qp_o, rd_ie_o, rd_qe_o, rd_il_o, rd_ql_o;
    logic [TSW-1:0]  rd_tstamp_o;
    logic [7:0]      rd_seq_o, ovf_cnt_o;
    logic [3:0]      level_o;

    gps_corr_dump_fifo #(.DEPTH(DEPTH), .DW(DW), .TSW(TSW)) dut (
        .mclk(mclk), .mrst(mrst), .dump_i(dump_i), .acq_i(acq_i),
        .ip_i(ip_i), .qp_i(qp_i), .ie_i(ie_i), .qe_i(qe_i), .il_i(il_i), .ql_i(ql_i),
        .tstamp_i(tstamp_i), .pop_i(pop_i), .flush_i(flush_i), .clr_ovf_i(clr_ovf_i),
        .rd_valid_o(rd_valid_o), .rd_ip_o(rd_ip_o), .rd_qp_o(rd_qp_o), .rd_ie_o(rd_ie_o),
        .rd_qe_o(rd_qe_o), .rd_il_o(rd_il_o), .rd_ql_o(rd_ql_o), .rd_tstamp_o(rd_tstamp_o),
        .rd_acq_o(rd_acq_o), .rd_seq_o(rd_seq_o), .level_o(level_o), .full_o(full_o),
        .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
    );

    always #5 mclk = ~mclk;

    logic [EW-1:0] dut_head;
    assign dut_head = {rd_seq_o, rd_acq_o, rd_tstamp_o, rd_ip_o, rd_qp_o,
                       rd_ie_o, rd_qe_o, rd_il_o, rd_ql_o};

    int errs   = 0;
    int checks = 0;

    // Reference model: a queue of stored entries plus counters.
    logic [EW-1:0] mq[$];
    logic [7:0]    m_seq, m_cnt;
    logic          m_ovf, m_prev;

    task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq  = 8'd0;
        m_cnt  = 8'd0;
        m_ovf  = 1'b0;
        m_prev = 1'b1;  // strobe must be seen low after reset before it can rise
    endtask

    task automatic model_step();
        logic cap, pope, rej;
        logic [EW-1:0] ent;
        if (mrst) begin
            model_reset();
            return;
        end
        cap    = dump_i && !m_prev;
        m_prev = dump_i;
        pope   = pop_i && (mq.size() != 0);
        rej    = cap && (mq.size() == DEPTH) && !pope;
        if (clr_ovf_i) begin
            m_ovf = 1'b0;
            m_cnt = 8'd0;
        end
        if (rej) begin
            m_ovf = 1'b1;
            if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        end
        ent = {m_seq, acq_i, tstamp_i, ip_i, qp_i, ie_i, qe_i, il_i, ql_i};
        if (flush_i) begin
            mq.delete();
        end else begin
            if (pope) void'(mq.pop_front());
            if (cap && !rej) mq.push_back(ent);
        end
        if (cap) m_seq = m_seq + 8'd1;
    endtask

    task automatic check_all();
        chk("valid",   192'(rd_valid_o), 192'(mq.size() != 0));
        chk("level",   192'(level_o),    192'(mq.size()));
        chk("full",    192'(full_o),     192'(mq.size() == DEPTH));
        chk("ovf",     192'(ovf_o),      192'(m_ovf));
        chk("ovf_cnt", 192'(ovf_cnt_o),  192'(m_cnt));
        if (mq.size() != 0) chk("head", 192'(dut_head), 192'(mq[0]));
    endtask

    task automatic tick();
        model_step();
        @(posedge mclk);
        #1;
        check_all();
    endtask

    task automatic rand_data();
        ip_i     = DW'($urandom);
        qp_i     = DW'($urandom);
        ie_i     = DW'($urandom);
        qe_i     = DW'($urandom);
        il_i     = DW'($urandom);
        ql_i     = DW'($urandom);
        tstamp_i = $urandom;
        acq_i    = 1'($urandom);
    endtask

    task automatic capture();
        rand_data();
        dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        tick();
    endtask

    // Asynchronous reset asserted mid-cycle, away from the clock edge.
    task automatic do_reset();
        mrst = 1'b1;
        #1;
        chk("arst_valid", 192'(rd_valid_o), 192'(0));
        chk("arst_level", 192'(level_o),    192'(0));
        model_reset();
        tick();
        mrst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] tail_ip;
        mrst = 1'b1;
        dump_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clr_ovf_i = 1'b0;
        rand_data();
        model_reset();
        tick();
        tick();
        chk("rst_data", 192'(dut_head), 192'(0));
        chk("rst_ovf",  192'(ovf_o),    192'(0));
        mrst = 1'b0;
        tick();

        // First capture: visible one cycle after the rising edge.
        rand_data();
        ip_i = 20'h12345;
        tstamp_i = 32'hA5A5_0001;
        dump_i = 1'b1;
        tick();
        chk("first_valid", 192'(rd_valid_o),  192'(1));
        chk("first_ip",    192'(rd_ip_o),     192'(20'h12345));
        chk("first_ts",    192'(rd_tstamp_o), 192'(32'hA5A5_0001));
        chk("first_seq",   192'(rd_seq_o),    192'(0));
        chk("first_level", 192'(level_o),     192'(1));

        // Held strobe yields one entry only.
        repeat (49) begin
            rand_data();
            tick();
        end
        chk("held_level", 192'(level_o), 192'(1));
        dump_i = 1'b0;
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("pop_valid", 192'(rd_valid_o), 192'(0));
        chk("pop_level", 192'(level_o),    192'(0));

        // Reset mid-operation, with the strobe high across release.
        capture();
        capture();
        dump_i = 1'b1;
        do_reset();
        tick();
        chk("rel_high_level", 192'(level_o), 192'(0));
        dump_i = 1'b0;
        tick();

        // Ten captures into an 8-deep FIFO.
        repeat (10) capture();
        chk("ovf10_level", 192'(level_o),   192'(8));
        chk("ovf10_full",  192'(full_o),    192'(1));
        chk("ovf10_cnt",   192'(ovf_cnt_o), 192'(2));
        chk("ovf10_flag",  192'(ovf_o),     192'(1));
        for (int i = 0; i < 8; i++) begin
            chk("drain_seq", 192'(rd_seq_o), 192'(i));
            pop_i = 1'b1;
            tick();
            pop_i = 1'b0;
        end
        rand_data();
        dump_i = 1'b1;
        tick();
        chk("seq_after_drops", 192'(rd_seq_o), 192'(10));
        dump_i = 1'b0;
        tick();

        // Full FIFO: capture and pop together.
        repeat (7) capture();
        chk("full_again", 192'(full_o), 192'(1));
        rand_data();
        tail_ip = ip_i;
        dump_i = 1'b1;
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        dump_i = 1'b0;
        chk("pushpop_level", 192'(level_o),   192'(8));
        chk("pushpop_cnt",   192'(ovf_cnt_o), 192'(2));
        tick();
        repeat (7) begin
            pop_i = 1'b1;
            tick();
        end
        pop_i = 1'b0;
        chk("tail_seq", 192'(rd_seq_o), 192'(18));
        chk("tail_ip",  192'(rd_ip_o),  192'(tail_ip));
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;

        // Flush coincident with a capture.
        do_reset();
        tick();
        repeat (3) capture();
        chk("pre_flush_level", 192'(level_o), 192'(3));
        rand_data();
        dump_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        dump_i = 1'b0;
        chk("flush_level", 192'(level_o),    192'(0));
        chk("flush_valid", 192'(rd_valid_o), 192'(0));
        chk("flush_ovf",   192'(ovf_o),      192'(0));
        tick();
        rand_data();
        dump_i = 1'b1;
        tick();
        chk("flush_next_seq", 192'(rd_seq_o), 192'(4));
        dump_i = 1'b0;
        tick();

        // Saturating overflow counter and clear-with-overflow.
        while (mq.size() < DEPTH) capture();
        repeat (300) capture();
        chk("sat_cnt",  192'(ovf_cnt_o), 192'(255));
        chk("sat_flag", 192'(ovf_o),     192'(1));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_keeps_cnt", 192'(ovf_cnt_o), 192'(255));
        repeat (8) capture();
        rand_data();
        dump_i = 1'b1;
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        dump_i = 1'b0;
        chk("clr_ovf_cnt",  192'(ovf_cnt_o), 192'(1));
        chk("clr_ovf_flag", 192'(ovf_o),     192'(1));
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("clr_cnt",  192'(ovf_cnt_o), 192'(0));
        chk("clr_flag", 192'(ovf_o),     192'(0));

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rand_data();
            if ($urandom_range(0, 2) == 0) dump_i = ~dump_i;
            pop_i     = ($urandom_range(0, 3) == 0);
            flush_i   = ($urandom_range(0, 99) == 0);
            clr_ovf_i = ($urandom_range(0, 63) == 0);
            tick();
        end
        pop_i = 1'b0; flush_i = 1'b0; clr_ovf_i = 1'b0; dump_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
